// File: rtl/sw_word_loader.sv
// Assembles four switch bytes, captured on load-button rising edges, into a
// little-endian 32-bit word and writes it to sequential memory addresses with a req/ack handshake.
module sw_word_loader #(
  parameter int ADDR_W = 6
) (
  input  logic              clk_100MHz,
  input  logic              rst,
  input  logic              load_btn,
  input  logic              cancel,
  input  logic [7:0]        SW,
  input  logic              mem_ack,
  output logic              mem_wr_en,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  output logic [1:0]        byte_idx,
  output logic              busy,
  output logic              full
);

  localparam logic [ADDR_W-1:0] LAST_ADDR = {ADDR_W{1'b1}};

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WRITE = 2'd1,
    FULL  = 2'd2
  } state_t;

  state_t            state, state_nxt;
  logic              load_btn_q;
  logic              btn_mask;
  logic              load_pulse;
  logic [ADDR_W-1:0] addr_nxt;
  logic [31:0]       wdata_nxt;
  logic [1:0]        idx_nxt;

  // btn_mask remembers a button already held at reset so its level is not
  // mistaken for a fresh press on the first cycle afterwards.
  assign load_pulse = load_btn & ~load_btn_q & ~btn_mask;

  assign busy      = (state == WRITE);
  assign full      = (state == FULL);
  assign mem_wr_en = busy;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values; blocking here would create ordering races.
  always_ff @(posedge clk_100MHz) begin
    if (rst) begin
      state      <= IDLE;
      load_btn_q <= 1'b0;
      btn_mask   <= load_btn;
      mem_addr   <= '0;
      mem_wdata  <= '0;
      byte_idx   <= '0;
    end else begin
      state      <= state_nxt;
      load_btn_q <= load_btn;
      btn_mask   <= 1'b0;
      mem_addr   <= addr_nxt;
      mem_wdata  <= wdata_nxt;
      byte_idx   <= idx_nxt;
    end
  end

  // NOTE: every combinational output gets a default first so no path leaves
  // it unassigned, which would infer a latch.
  always_comb begin
    state_nxt = state;
    addr_nxt  = mem_addr;
    wdata_nxt = mem_wdata;
    idx_nxt   = byte_idx;

    unique case (state)
      IDLE: begin
        if (cancel) begin
          wdata_nxt = '0;
          idx_nxt   = '0;
        end else if (load_pulse) begin
          wdata_nxt[8*byte_idx +: 8] = SW;
          idx_nxt = byte_idx + 2'd1;
          if (byte_idx == 2'd3) state_nxt = WRITE;
        end
      end
      WRITE: begin
        if (mem_ack) begin
          wdata_nxt = '0;
          idx_nxt   = '0;
          addr_nxt  = mem_addr + ADDR_W'(1);
          state_nxt = (mem_addr == LAST_ADDR) ? FULL : IDLE;
        end
      end
      FULL: ;
      default: state_nxt = IDLE;
    endcase
  end

endmodule

// File: tb/tb_sw_word_loader.sv
// Directed bench for sw_word_loader: stimulus pushes expected writes into a
// scoreboard queue, a negedge monitor pops and compares on each acked write.
module tb_sw_word_loader;

  localparam int ADDR_W = 6;

  logic              clk;
  logic              rst;
  logic              load_btn;
  logic              cancel;
  logic [7:0]        sw;
  logic              mem_ack;
  logic              mem_wr_en;
  logic [ADDR_W-1:0] mem_addr;
  logic [31:0]       mem_wdata;
  logic [1:0]        byte_idx;
  logic              busy;
  logic              full;

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [31:0]       data;
  } wr_t;

  wr_t expq[$];
  int  tests = 0;
  int  fails = 0;
  int  wr_cycles = 0;

  sw_word_loader #(.ADDR_W(ADDR_W)) dut (
    .clk_100MHz(clk),
    .rst       (rst),
    .load_btn  (load_btn),
    .cancel    (cancel),
    .SW        (sw),
    .mem_ack   (mem_ack),
    .mem_wr_en (mem_wr_en),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .byte_idx  (byte_idx),
    .busy      (busy),
    .full      (full)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Monitor: every accepted write must match the head of the scoreboard.
  always @(negedge clk) begin
    if (!rst && mem_wr_en === 1'b1) begin
      wr_cycles++;
      if (mem_ack === 1'b1) begin
        if (expq.size() == 0) begin
          check("unexpected_write", 32'(mem_addr), 32'hFFFF_FFFF);
        end else begin
          wr_t e;
          e = expq.pop_front();
          check("wr_addr", 32'(mem_addr), 32'(e.addr));
          check("wr_data", mem_wdata, e.data);
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic press(input logic [7:0] b);
    sw = b;
    load_btn = 1'b1;
    tick();
    load_btn = 1'b0;
    tick();
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] w;
    rst = 1'b1; load_btn = 1'b0; cancel = 1'b0; sw = 8'h00; mem_ack = 1'b1;
    tick(); tick();
    rst = 1'b0;
    tick();
    check("rst_wr_en", 32'(mem_wr_en), 0);
    check("rst_addr",  32'(mem_addr), 0);
    check("rst_wdata", mem_wdata, 0);
    check("rst_idx",   32'(byte_idx), 0);
    check("rst_busy_full", {30'd0, busy, full}, 0);

    // Basic word with ack tied high.
    wr_cycles = 0;
    press(8'h78); press(8'h56); press(8'h34);
    check("partial_data", mem_wdata, 32'h0034_5678);
    check("partial_idx", 32'(byte_idx), 3);
    expq.push_back('{addr: 6'd0, data: 32'h1234_5678});
    press(8'h12);
    check("w0_wr_cycles", wr_cycles, 1);
    check("w0_addr_after", 32'(mem_addr), 1);
    check("w0_idx_after", 32'(byte_idx), 0);
    check("w0_data_after", mem_wdata, 0);

    // Long hold produces a single capture.
    sw = 8'hAA; load_btn = 1'b1;
    repeat (50) tick();
    check("hold_idx", 32'(byte_idx), 1);
    check("hold_byte", 32'(mem_wdata[7:0]), 32'hAA);
    load_btn = 1'b0; tick();
    cancel = 1'b1; tick(); cancel = 1'b0; tick();
    check("cancel_idx", 32'(byte_idx), 0);
    check("cancel_addr", 32'(mem_addr), 1);

    // Delayed ack: six write cycles, a load edge ignored meanwhile.
    mem_ack = 1'b0;
    press(8'h11); press(8'h22); press(8'h33);
    expq.push_back('{addr: 6'd1, data: 32'h4433_2211});
    wr_cycles = 0;
    sw = 8'h44; load_btn = 1'b1; tick();
    load_btn = 1'b0;
    check("wait_busy", 32'(busy), 1);
    for (int i = 0; i < 5; i++) begin
      if (i == 1) begin sw = 8'hFF; load_btn = 1'b1; end
      if (i == 3) load_btn = 1'b0;
      tick();
      check("wait_data_stable", mem_wdata, 32'h4433_2211);
      check("wait_addr_stable", 32'(mem_addr), 1);
    end
    mem_ack = 1'b1; tick(); mem_ack = 1'b0;
    check("w1_wr_cycles", wr_cycles, 6);
    check("w1_addr_after", 32'(mem_addr), 2);
    check("w1_idx_after", 32'(byte_idx), 0);

    // Cancel beats a simultaneous load edge.
    press(8'h01); press(8'h02);
    cancel = 1'b1; sw = 8'h99; load_btn = 1'b1; tick();
    cancel = 1'b0; load_btn = 1'b0; tick();
    check("cxl_idx", 32'(byte_idx), 0);
    check("cxl_data", mem_wdata, 0);
    check("cxl_addr", 32'(mem_addr), 2);

    // Reset mid-write abandons it; button held through reset gives no pulse.
    press(8'hA1); press(8'hA2); press(8'hA3); press(8'hA4);
    check("pre_rst_wr_en", 32'(mem_wr_en), 1);
    load_btn = 1'b1; rst = 1'b1; tick(); rst = 1'b0;
    check("rst_write_wr_en", 32'(mem_wr_en), 0);
    check("rst_write_addr", 32'(mem_addr), 0);
    check("rst_write_busy", 32'(busy), 0);
    tick(); tick();
    check("held_btn_no_pulse", 32'(byte_idx), 0);
    load_btn = 1'b0; tick();

    // Fill every address until FULL.
    mem_ack = 1'b1;
    for (int a = 0; a < 64; a++) begin
      w = {8'(a + 3), 8'(a + 2), 8'(a + 1), 8'(a)};
      if (a == 63) check("not_full_yet", 32'(full), 0);
      expq.push_back('{addr: 6'(a), data: w});
      for (int b = 0; b < 4; b++) press(w[8*b +: 8]);
    end
    check("full_set", 32'(full), 1);
    check("full_addr_wrap", 32'(mem_addr), 0);
    check("full_wr_en", 32'(mem_wr_en), 0);
    press(8'h55); press(8'h66);
    check("full_ignore_idx", 32'(byte_idx), 0);
    check("full_ignore_data", mem_wdata, 0);
    check("full_stays", 32'(full), 1);
    rst = 1'b1; tick(); rst = 1'b0; tick();
    check("rst_clears_full", 32'(full), 0);
    check("scoreboard_empty", expq.size(), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/sw_word_loader.md
SW_WORD_LOADER -- requirements
Module: sw_word_loader

Interface
REQ-001 The block SHALL have parameter ADDR_W, default 6, meaning the word-address width (DEPTH = 2^ADDR_W words).
REQ-002 The block SHALL have port clk_100MHz, input, 1, the single system clock; all logic is on its rising edge.
REQ-003 The block SHALL have port rst, input, 1, reset; reset is synchronous and active-high.
REQ-004 The block SHALL have port load_btn, input, 1, debounced button level; each rising edge loads one byte.
REQ-005 The block SHALL have port cancel, input, 1, level; discards the partial word.
REQ-006 The block SHALL have port SW, input, 8, the byte value to load.
REQ-007 The block SHALL have port mem_ack, input, 1, memory accepts the current write.
REQ-008 The block SHALL have port mem_wr_en, output, 1, write request.
REQ-009 The block SHALL have port mem_addr, output, ADDR_W, word address of the write.
REQ-010 The block SHALL have port mem_wdata, output, 32, assembled word.
REQ-011 The block SHALL have port byte_idx, output, 2, number of bytes captured for the current word.
REQ-012 The block SHALL have port busy, output, 1, high in WRITE state.
REQ-013 The block SHALL have port full, output, 1, high in FULL state.

Function
REQ-014 The block SHALL register load_btn each cycle and form load_pulse = load_btn & ~load_btn_q; one pulse per rising edge, whatever the hold length.
REQ-015 The FSM SHALL have states IDLE, WRITE and FULL, with busy = (state==WRITE) and full = (state==FULL).
REQ-016 In IDLE, on load_pulse without cancel, the block SHALL write SW into mem_wdata[8*byte_idx+7 : 8*byte_idx] (little-endian: first byte to [7:0]) and increment byte_idx modulo 4.
REQ-017 In IDLE, when load_pulse captures the byte at byte_idx==3, the block SHALL enter WRITE at that same edge, so mem_wr_en is high from the next cycle.
REQ-018 In WRITE, the block SHALL hold mem_wr_en=1 and keep mem_addr and mem_wdata stable until a cycle with mem_ack=1.
REQ-019 On the edge where mem_wr_en and mem_ack are both 1, the block SHALL clear byte_idx and mem_wdata to 0 and increment mem_addr.
REQ-020 On that edge, if mem_addr == DEPTH-1, the block SHALL go to FULL and mem_addr SHALL wrap to 0; otherwise it SHALL go to IDLE.
REQ-021 mem_ack SHALL be ignored outside WRITE.
REQ-022 In WRITE and in FULL, load_pulse and cancel SHALL be ignored, and the edge detector SHALL keep tracking load_btn.
REQ-023 In IDLE, cancel=1 SHALL clear byte_idx and mem_wdata to 0 and leave mem_addr unchanged.
REQ-024 If cancel and load_pulse occur in the same cycle, cancel SHALL win and no byte is captured.
REQ-025 FULL SHALL be exited only by rst.
REQ-026 mem_wr_en SHALL be 0 in IDLE and FULL.

Reset
REQ-027 When rst=1 at a clock edge, the block SHALL set state=IDLE, mem_wr_en=0, mem_addr=0, mem_wdata=0, byte_idx=0, busy=0, full=0 and load_btn_q=0.
REQ-028 rst SHALL take priority over every other input in every state, including mid-WRITE, where the pending write is abandoned without an ack.
REQ-029 If load_btn is already high when rst falls, the first cycle after reset SHALL produce no load_pulse; the next pulse requires a fresh rising edge.

Verification
REQ-030 Bytes 0x78, 0x56, 0x34, 0x12 with mem_ack tied to 1 -> one-cycle mem_wr_en, mem_addr=0, mem_wdata=0x12345678; then mem_addr=1, byte_idx=0.
REQ-031 load_btn held high for 50 cycles with SW=0xAA -> byte_idx goes 0->1 exactly once, mem_wdata[7:0]=0xAA.
REQ-032 Four bytes loaded with mem_ack=0 for 5 cycles then 1 -> mem_wr_en high for 6 cycles with stable data, and a load edge during that time is ignored.
REQ-033 Two bytes loaded, then cancel together with a load edge -> byte_idx=0, mem_wdata=0, mem_addr unchanged.
REQ-034 64 words written with ADDR_W=6 -> full=1 and mem_addr=0 after the 64th ack; further loads do nothing; rst clears full.
REQ-035 rst asserted in WRITE -> mem_wr_en=0, mem_addr=0, state IDLE on the next cycle.
